uart_rx_async: RTL and testbench

//  Asynchronous UART receiver, receive-side counterpart of the UART transmitter in the CoreUARTapb core.

---
 rtl/uart_rx_async.sv | 155 +++++++++++++++
 tb/tb_uart_rx_async.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_async.sv
// 16x-oversampled UART receiver: synchronises and majority-filters rx, frames 7/8 data bits with
// optional parity, then hands the byte to a holding register or to an external RX FIFO.
module uart_rx_async #(
    parameter int RX_FIFO     = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       fifo_write
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_taps;
    logic [3:0]             r_sampCnt;
    logic [2:0]             r_bitCnt;
    logic [7:0]             r_shift;
    logic                   r_parSample;
    logic                   r_stopSample;

    logic                   w_rxSync;
    logic                   w_rxFilt;
    logic                   w_lastBit;
    logic [7:0]             w_data;
    logic                   w_parErr;

    assign w_rxSync  = r_sync[SYNC_STAGES-1];
    assign w_rxFilt  = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);
    assign w_lastBit = (r_bitCnt == (bit8 ? 3'd7 : 3'd6));
    // Bits enter at the MSB, so a 7-bit frame ends up in r_shift[7:1].
    assign w_data    = bit8 ? r_shift : {1'b0, r_shift[7:1]};
    assign w_parErr  = parity_en & (r_parSample != (odd_n_even ^ (^w_data)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_taps <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
            if (baud_clock) begin
                r_taps <= {r_taps[1:0], w_rxSync};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sampCnt    <= '0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_parSample  <= 1'b0;
            r_stopSample <= 1'b0;
            rx_byte      <= '0;
            rx_ready     <= 1'b0;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            overflow     <= 1'b0;
            fifo_write   <= 1'b0;
        end else begin
            fifo_write <= 1'b0;
            if (RX_FIFO != 0) begin
                rx_ready <= ~fifo_empty;
            end
            if (r_state == DELIVER) begin
                rx_byte     <= w_data;
                parity_err  <= w_parErr;
                framing_err <= ~r_stopSample;
                if (RX_FIFO == 0) begin
                    // A read in this same cycle consumed the old byte, so nothing is lost.
                    rx_ready <= 1'b1;
                    overflow <= read_rx_byte ? 1'b0 : (overflow | rx_ready);
                end else if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    fifo_write <= 1'b1;
                end
                r_state   <= IDLE;
                r_sampCnt <= '0;
            end else begin
                if (read_rx_byte) begin
                    parity_err  <= 1'b0;
                    framing_err <= 1'b0;
                    if (RX_FIFO == 0) begin
                        rx_ready <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                if (baud_clock) begin
                    r_sampCnt <= r_sampCnt + 4'd1;
                    case (r_state)
                        IDLE: begin
                            r_sampCnt <= '0;
                            if (!w_rxFilt) begin
                                r_state <= START;
                            end
                        end
                        START: begin
                            if (r_sampCnt == 4'd7) begin
                                r_sampCnt <= '0;
                                r_bitCnt  <= '0;
                                r_state   <= w_rxFilt ? IDLE : DATA;
                            end
                        end
                        DATA: begin
                            if (r_sampCnt == 4'd15) begin
                                r_shift  <= {w_rxFilt, r_shift[7:1]};
                                r_bitCnt <= r_bitCnt + 3'd1;
                                if (w_lastBit) begin
                                    r_sampCnt <= '0;
                                    r_state   <= parity_en ? PARITY : STOP;
                                end
                            end
                        end
                        PARITY: begin
                            if (r_sampCnt == 4'd15) begin
                                r_parSample <= w_rxFilt;
                                r_sampCnt   <= '0;
                                r_state     <= STOP;
                            end
                        end
                        STOP: begin
                            // Leaving at mid-stop lets a start bit arriving half a bit later be caught.
                            if (r_sampCnt == 4'd15) begin
                                r_stopSample <= w_rxFilt;
                                r_sampCnt    <= '0;
                                r_state      <= DELIVER;
                            end
                        end
                        default: begin
                            r_sampCnt <= '0;
                            r_state   <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_async.sv
// Self-checking bench for uart_rx_async: fixed frame vectors, hand-built corner sequences and
// random frames compared against a frame-level reference model.
module tb_uart_rx_async;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset;
    logic       baud_clock;
    logic       rx;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
    logic       read_rx_byte;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       fifo_write;

    int assertCount = 0;
    int failCount   = 0;
    int baudPhase   = 0;
    int latency     = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       useBit8;
        logic       usePar;
        logic       odd;
        logic       parBit;
        logic       stopBit;
        logic [7:0] expByte;
        logic       expPe;
        logic       expFe;
    } vec_t;

    vec_t vecs [10];

    uart_rx_async #(.RX_FIFO(0), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow),
        .fifo_write   (fifo_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk baud enable every fourth clock.
    initial begin
        baud_clock = 1'b0;
        forever begin
            @(negedge clk);
            baudPhase  = (baudPhase + 1) % 4;
            baud_clock = (baudPhase == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic useBit8, input logic usePar,
                                 input logic parBit, input logic stopBit);
        int nBits;
        nBits = useBit8 ? 8 : 7;
        @(posedge clk);
        while (baudPhase != 0) @(posedge clk);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (usePar) begin
            rx = parBit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic pulseRead();
        @(negedge clk);
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
        @(negedge clk);
    endtask

    task automatic setConfig(input logic useBit8, input logic usePar, input logic odd);
        bit8       = useBit8;
        parity_en  = usePar;
        odd_n_even = odd;
    endtask

    // Reference model: what a receiver should report for one complete frame.
    function automatic logic [9:0] modelFrame(input logic [7:0] data, input logic useBit8,
                                              input logic usePar, input logic odd,
                                              input logic parBit, input logic stopBit);
        logic [7:0] b;
        logic       pe;
        b  = useBit8 ? data : (data & 8'h7F);
        pe = usePar && (parBit != (odd ^ (^b)));
        return {b, pe, ~stopBit};
    endfunction

    task automatic checkFrame(input string tag, input logic [7:0] expByte, input logic expPe,
                              input logic expFe);
        checkOutput({tag, " rx_byte"}, rx_byte, expByte);
        checkOutput({tag, " parity_err"}, 8'(parity_err), 8'(expPe));
        checkOutput({tag, " framing_err"}, 8'(framing_err), 8'(expFe));
        checkOutput({tag, " rx_ready"}, 8'(rx_ready), 8'h01);
        checkOutput({tag, " overflow"}, 8'(overflow), 8'h00);
        pulseRead();
        checkOutput({tag, " cleared rx_ready"}, 8'(rx_ready), 8'h00);
        checkOutput({tag, " cleared errors"}, {6'b0, parity_err, framing_err}, 8'h00);
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] d;
        logic       rb8, rpe, rodd, rpar, rstop;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h2A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b1};
        vecs[8] = '{8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[9] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        reset        = 1'b1;
        rx           = 1'b1;
        read_rx_byte = 1'b0;
        fifo_full    = 1'b0;
        fifo_empty   = 1'b1;
        setConfig(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("reset rx_byte", rx_byte, 8'h00);
        checkOutput("reset flags", {2'b0, rx_ready, parity_err, framing_err, overflow, fifo_write, 1'b0},
                    8'h00);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            setConfig(vecs[i].useBit8, vecs[i].usePar, vecs[i].odd);
            applyStimulus(vecs[i].data, vecs[i].useBit8, vecs[i].usePar, vecs[i].parBit, vecs[i].stopBit);
            checkFrame($sformatf("vec%0d", i), vecs[i].expByte, vecs[i].expPe, vecs[i].expFe);
        end

        // Start glitch of five baud ticks must be rejected without producing a byte.
        setConfig(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        while (baudPhase != 0) @(posedge clk);
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        checkOutput("glitch rx_ready", 8'(rx_ready), 8'h00);

        // Two unread frames: second overwrites, overflow raised; read clears everything.
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf rx_byte", rx_byte, 8'h22);
        checkOutput("ovf overflow", 8'(overflow), 8'h01);
        checkOutput("ovf rx_ready", 8'(rx_ready), 8'h01);
        pulseRead();
        checkOutput("ovf cleared", {6'b0, overflow, rx_ready}, 8'h00);

        // Measure start-to-ready delay, then land a read exactly on the delivery cycle.
        fork
            applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
            begin
                wait (rx == 1'b0);
                latency = 0;
                while (!rx_ready && latency < 2000) begin
                    @(negedge clk);
                    latency++;
                end
            end
        join
        checkOutput("latency rx_ready", 8'(rx_ready), 8'h01);
        checkOutput("latency rx_byte", rx_byte, 8'h33);
        fork
            applyStimulus(8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
            begin
                wait (rx == 1'b0);
                repeat (latency - 1) @(negedge clk);
                read_rx_byte = 1'b1;
                @(negedge clk);
                read_rx_byte = 1'b0;
            end
        join
        checkOutput("rd-deliver rx_byte", rx_byte, 8'h44);
        checkOutput("rd-deliver rx_ready", 8'(rx_ready), 8'h01);
        checkOutput("rd-deliver overflow", 8'(overflow), 8'h00);
        pulseRead();

        // Reset in the middle of a data bit discards the frame and clears all outputs.
        setConfig(1'b0, 1'b1, 1'b1);
        applyStimulus(8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("pre-reset rx_byte", rx_byte, 8'h7F);
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midframe reset rx_byte", rx_byte, 8'h00);
        checkOutput("midframe reset flags", {3'b0, rx_ready, parity_err, framing_err, overflow, fifo_write},
                    8'h00);
        repeat (2 * BIT_CLKS) @(negedge clk);
        applyStimulus(8'h2A, 1'b0, 1'b1, 1'b0, 1'b1);
        checkFrame("post-reset", 8'h2A, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            d     = 8'($urandom);
            rb8   = 1'($urandom_range(0, 1));
            rpe   = 1'($urandom_range(0, 1));
            rodd  = 1'($urandom_range(0, 1));
            rpar  = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            setConfig(rb8, rpe, rodd);
            m = modelFrame(d, rb8, rpe, rodd, rpar, rstop);
            applyStimulus(d, rb8, rpe, rpar, rstop);
            checkFrame($sformatf("rand%0d", i), m[9:2], m[1], m[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
